dadda_dot_accumulator: RTL



---
 rtl/dadda_dot_accumulator_if.sv | 28 ++
 rtl/dadda_dot_accumulator.sv | 86 ++++++++
 2 files changed

// File: rtl/dadda_dot_accumulator_if.sv
// Product-stream in / dot-product result out handshake bundle for dadda_dot_accumulator.
// The accumulator takes the slave view; the product source and result sink take the master view.
interface dadda_dot_accumulator_if #(
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 256
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_p;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_p, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/dadda_dot_accumulator.sv
// Saturating dot-product accumulator behind the 8x8 Dadda multiplier: one beat per cycle,
// result presented the cycle after the terminating beat and held (input stalled) until taken.
module dadda_dot_accumulator #(
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 256
) (
  input logic                    clk,
  input logic                    rst,
  dadda_dot_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;

  logic             accept;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum;
  logic             sat;
  logic [CNT_W-1:0] cnt_inc;
  logic             done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // A fresh vector starts from zero so nothing needs clearing on the way out of HOLD.
  always_comb begin
    accept  = bus.in_valid && (state != HOLD);
    base    = (state == IDLE) ? '0 : acc;
    sum     = {1'b0, base} + (ACC_W + 1)'(bus.in_p);
    sat     = sum[ACC_W];
    cnt_inc = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
    done    = bus.in_last || (cnt_inc == CNT_LAST);
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_nxt   = sat ? ACC_MAX : sum[ACC_W-1:0];
          cnt_nxt   = cnt_inc;
          ovf_nxt   = sat || ((state == ACCUM) && ovf);
          state_nxt = done ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result fields read as zero whenever no result is being offered.
  always_comb begin
    bus.in_ready  = (state != HOLD);
    bus.out_valid = (state == HOLD);
    bus.out_sum   = (state == HOLD) ? acc : '0;
    bus.out_count = (state == HOLD) ? cnt : '0;
    bus.out_ovf   = (state == HOLD) && ovf;
  end
endmodule
